// File: rtl/sd_card_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sd_card_detect_ctrl
// Description : SD card-detect synchroniser, debouncer and insertion/removal
//               status and interrupt logic. Debounce states and counter are
//               built only when SD_CD_DEBOUNCE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_card_detect_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter logic        CD_POL          = 1'b0
) (
    input  logic ex_clk,
    input  logic ex_resetn,
    input  logic sd_cd,
    input  logic ins_sts_en,
    input  logic rem_sts_en,
    input  logic ins_sig_en,
    input  logic rem_sig_en,
    input  logic ins_clr,
    input  logic rem_clr,
    output logic card_inserted,
    output logic card_stable,
    output logic ins_sts,
    output logic rem_sts,
    output logic irq
);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic       c_absent  = ~CD_POL;

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_debounce_cycles
        $error("sd_card_detect_ctrl: DEBOUNCE_CYCLES must be in 2..65535");
    end

    logic       r_sync1;
    logic       r_sync2;
    logic       w_present;
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_ins_evt;
    logic       w_rem_evt;
    logic       w_inserted_nxt;
    logic       r_card_inserted;
    logic       r_ins_sts;
    logic       r_rem_sts;
    logic       r_irq;

    // Reset parks the synchroniser at the absent level so no false insertion
    always_ff @(posedge ex_clk or negedge ex_resetn) begin
        if (!ex_resetn) begin
            r_sync1 <= c_absent;
            r_sync2 <= c_absent;
        end else begin
            r_sync1 <= sd_cd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_present = (r_sync2 == CD_POL);

`ifdef SD_CD_DEBOUNCE_EN
    localparam logic [1:0]  S_DEB_IN   = 2'd1;
    localparam logic [1:0]  S_DEB_OUT  = 2'd3;
    localparam logic [15:0] c_cnt_last = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_card_stable;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ins_evt   = 1'b0;
        w_rem_evt   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_present) begin
                    w_state_nxt = S_DEB_IN;
                    w_cnt_nxt   = '0;
                end
            end
            S_DEB_IN: begin
                if (!w_present) begin
                    w_state_nxt = S_EMPTY;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_PRESENT;
                    w_cnt_nxt   = '0;
                    w_ins_evt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_PRESENT: begin
                if (!w_present) begin
                    w_state_nxt = S_DEB_OUT;
                    w_cnt_nxt   = '0;
                end
            end
            S_DEB_OUT: begin
                if (w_present) begin
                    w_state_nxt = S_PRESENT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_EMPTY;
                    w_cnt_nxt   = '0;
                    w_rem_evt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_inserted_nxt = (w_state_nxt == S_PRESENT) || (w_state_nxt == S_DEB_OUT);

    always_ff @(posedge ex_clk or negedge ex_resetn) begin
        if (!ex_resetn) begin
            r_cnt         <= '0;
            r_card_stable <= 1'b1;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_card_stable <= (w_state_nxt == S_EMPTY) || (w_state_nxt == S_PRESENT);
        end
    end

    assign card_stable = r_card_stable;
`else
    always_comb begin
        w_state_nxt = r_state;
        w_ins_evt   = 1'b0;
        w_rem_evt   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_present) begin
                    w_state_nxt = S_PRESENT;
                    w_ins_evt   = 1'b1;
                end
            end
            S_PRESENT: begin
                if (!w_present) begin
                    w_state_nxt = S_EMPTY;
                    w_rem_evt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    assign w_inserted_nxt = (w_state_nxt == S_PRESENT);
    assign card_stable    = 1'b1;
`endif

    // A set on the same edge as a clear wins; enables only gate new events
    always_ff @(posedge ex_clk or negedge ex_resetn) begin
        if (!ex_resetn) begin
            r_state         <= S_EMPTY;
            r_card_inserted <= 1'b0;
            r_ins_sts       <= 1'b0;
            r_rem_sts       <= 1'b0;
            r_irq           <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_card_inserted <= w_inserted_nxt;
            r_ins_sts       <= (w_ins_evt & ins_sts_en) | (r_ins_sts & ~ins_clr);
            r_rem_sts       <= (w_rem_evt & rem_sts_en) | (r_rem_sts & ~rem_clr);
            r_irq           <= (r_ins_sts & ins_sig_en) | (r_rem_sts & rem_sig_en);
        end
    end

    assign card_inserted = r_card_inserted;
    assign ins_sts       = r_ins_sts;
    assign rem_sts       = r_rem_sts;
    assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sd_card_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_card_detect_ctrl
// Description : Directed scoreboard bench for sd_card_detect_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_card_detect_ctrl;

    localparam int N = 8;
`ifdef SD_CD_DEBOUNCE_EN
    localparam int LAT = N + 3;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit DEB = 1'b0;
`endif

    localparam int SIG_CI = 0, SIG_ST = 1, SIG_INS = 2, SIG_REM = 3, SIG_IRQ = 4;

    logic ex_clk     = 1'b0;
    logic ex_resetn  = 1'b0;
    logic sd_cd      = 1'b1;
    logic ins_sts_en = 1'b1;
    logic rem_sts_en = 1'b1;
    logic ins_sig_en = 1'b1;
    logic rem_sig_en = 1'b1;
    logic ins_clr    = 1'b0;
    logic rem_clr    = 1'b0;
    logic card_inserted, card_stable, ins_sts, rem_sts, irq;

    sd_card_detect_ctrl #(
        .DEBOUNCE_CYCLES(N),
        .CD_POL         (1'b0)
    ) dut (
        .ex_clk       (ex_clk),
        .ex_resetn    (ex_resetn),
        .sd_cd        (sd_cd),
        .ins_sts_en   (ins_sts_en),
        .rem_sts_en   (rem_sts_en),
        .ins_sig_en   (ins_sig_en),
        .rem_sig_en   (rem_sig_en),
        .ins_clr      (ins_clr),
        .rem_clr      (rem_clr),
        .card_inserted(card_inserted),
        .card_stable  (card_stable),
        .ins_sts      (ins_sts),
        .rem_sts      (rem_sts),
        .irq          (irq)
    );

    always #5 ex_clk = ~ex_clk;

    typedef struct {
        string tag;
        int    at;
        int    sig;
        bit    val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   base;

    function automatic logic dut_val(int sig);
        case (sig)
            SIG_CI:  return card_inserted;
            SIG_ST:  return card_stable;
            SIG_INS: return ins_sts;
            SIG_REM: return rem_sts;
            default: return irq;
        endcase
    endfunction

    task automatic compare(string tag, int sig, bit val);
        logic obs;
        obs = dut_val(sig);
        n_cmp++;
        assert (obs === val) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, val);
        end
    endtask

    task automatic push(string tag, int at, int sig, bit val);
        exp_t e;
        e.tag = tag;
        e.at  = at;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    // Advance n edges; after each edge, retire every expectation due on it
    task automatic run(int n);
        repeat (n) begin
            @(posedge ex_clk);
            cyc++;
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    compare(sb[i].tag, sb[i].sig, sb[i].val);
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic check_reset_values(string pfx);
        compare({pfx, "_ci"},     SIG_CI,  1'b0);
        compare({pfx, "_stable"}, SIG_ST,  1'b1);
        compare({pfx, "_ins"},    SIG_INS, 1'b0);
        compare({pfx, "_rem"},    SIG_REM, 1'b0);
        compare({pfx, "_irq"},    SIG_IRQ, 1'b0);
    endtask

    initial begin
        run(3);
        check_reset_values("rst");

        // Reset release with card absent: nothing may happen
        ex_resetn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            push($sformatf("idle_ci_%0d", k),  cyc + k, SIG_CI,  1'b0);
            push($sformatf("idle_ins_%0d", k), cyc + k, SIG_INS, 1'b0);
            push($sformatf("idle_rem_%0d", k), cyc + k, SIG_REM, 1'b0);
            push($sformatf("idle_irq_%0d", k), cyc + k, SIG_IRQ, 1'b0);
        end
        run(20);

        // Insertion
        base  = cyc;
        sd_cd = 1'b0;
        push("ins_ci_early", base + LAT - 1, SIG_CI,  1'b0);
        push("ins_ci",       base + LAT,     SIG_CI,  1'b1);
        push("ins_sts_early",base + LAT - 1, SIG_INS, 1'b0);
        push("ins_sts",      base + LAT,     SIG_INS, 1'b1);
        push("ins_irq_early",base + LAT,     SIG_IRQ, 1'b0);
        push("ins_irq",      base + LAT + 1, SIG_IRQ, 1'b1);
        for (int k = 1; k <= LAT + 2; k++)
            push($sformatf("ins_stable_%0d", k), base + k, SIG_ST,
                 (DEB && k >= 3 && k < LAT) ? 1'b0 : 1'b1);
        run(LAT + 2);

        // ins_clr pulse
        base    = cyc;
        ins_clr = 1'b1;
        push("ins_clr_sts", base + 1, SIG_INS, 1'b0);
        push("ins_clr_irq", base + 2, SIG_IRQ, 1'b0);
        run(1);
        ins_clr = 1'b0;
        run(2);

`ifdef SD_CD_DEBOUNCE_EN
        // Five-cycle removal glitch while present
        base  = cyc;
        sd_cd = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            push($sformatf("glitch_ci_%0d", k), base + k, SIG_CI, 1'b1);
            push($sformatf("glitch_stable_%0d", k), base + k, SIG_ST,
                 (k >= 3 && k <= 7) ? 1'b0 : 1'b1);
        end
        push("glitch_rem", base + 12, SIG_REM, 1'b0);
        push("glitch_ins", base + 12, SIG_INS, 1'b0);
        run(5);
        sd_cd = 1'b0;
        run(7);
`endif

        // Removal with removal signal disabled
        rem_sig_en = 1'b0;
        base  = cyc;
        sd_cd = 1'b1;
        push("rem_ci_early",  base + LAT - 1, SIG_CI,  1'b1);
        push("rem_ci",        base + LAT,     SIG_CI,  1'b0);
        push("rem_sts_early", base + LAT - 1, SIG_REM, 1'b0);
        push("rem_sts",       base + LAT,     SIG_REM, 1'b1);
        push("rem_irq_off1",  base + LAT + 1, SIG_IRQ, 1'b0);
        push("rem_irq_off2",  base + LAT + 2, SIG_IRQ, 1'b0);
        run(LAT + 2);

        // Enable signal; drop status enable, bit must stay set
        base       = cyc;
        rem_sig_en = 1'b1;
        rem_sts_en = 1'b0;
        push("rem_sig_irq",  base + 1, SIG_IRQ, 1'b1);
        push("rem_hold_1",   base + 1, SIG_REM, 1'b1);
        push("rem_hold_2",   base + 2, SIG_REM, 1'b1);
        run(2);

        base    = cyc;
        rem_clr = 1'b1;
        push("rem_clr_sts", base + 1, SIG_REM, 1'b0);
        push("rem_clr_irq", base + 2, SIG_IRQ, 1'b0);
        run(1);
        rem_clr    = 1'b0;
        rem_sts_en = 1'b1;
        run(1);

        // Re-insert, then clear on the same edge the removal sets
        base  = cyc;
        sd_cd = 1'b0;
        push("reins_ci", base + LAT, SIG_CI, 1'b1);
        run(LAT + 2);
        base  = cyc;
        sd_cd = 1'b1;
        push("race_rem_early", base + LAT - 1, SIG_REM, 1'b0);
        push("race_rem_set",   base + LAT,     SIG_REM, 1'b1);
        push("race_rem_hold",  base + LAT + 1, SIG_REM, 1'b1);
        run(LAT - 1);
        rem_clr = 1'b1;
        run(1);
        rem_clr = 1'b0;
        run(1);

        // Asynchronous reset mid-insertion, card present at release
        sd_cd = 1'b0;
        run(5);
        #3 ex_resetn = 1'b0;
        #1 check_reset_values("async_rst");
        run(2);
        ex_resetn = 1'b1;
        base = cyc;
        push("post_rst_ci_early",  base + LAT - 1, SIG_CI,  1'b0);
        push("post_rst_ci",        base + LAT,     SIG_CI,  1'b1);
        push("post_rst_ins_early", base + LAT - 1, SIG_INS, 1'b0);
        push("post_rst_ins",       base + LAT,     SIG_INS, 1'b1);
        run(LAT + 2);

        foreach (sb[i]) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: never reached, expected %b at cyc %0d", sb[i].tag, sb[i].val, sb[i].at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
